tri_edge_setup: RTL and testbench

TRI_EDGE_SETUP -- requirements
Module: tri_edge_setup

---
 rtl/tri_edge_setup_if.sv | 24 ++
 rtl/tri_edge_setup.sv | 203 ++++++++++++++++++++
 tb/tb_tri_edge_setup.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_edge_setup_if.sv
// Vertex handshake and active edge-coefficient bus of the triangle setup block.
interface tri_edge_setup_if;
  logic               vtx_valid;
  logic               vtx_ready;
  logic [9:0]         x1, y1, x2, y2, x3, y3;
  logic               frame_start;
  logic signed [10:0] A0, A1, A2, B0, B1, B2;
  logic signed [20:0] C0, C1, C2;
  logic signed [22:0] Area2;
  logic               tri_empty;
  logic               commit;

  // Upstream vertex source / scan timing side (drives vertices, reads coefficients).
  modport master (
    output vtx_valid, x1, y1, x2, y2, x3, y3, frame_start,
    input  vtx_ready, A0, A1, A2, B0, B1, B2, C0, C1, C2, Area2, tri_empty, commit
  );

  // Setup block side.
  modport slave (
    input  vtx_valid, x1, y1, x2, y2, x3, y3, frame_start,
    output vtx_ready, A0, A1, A2, B0, B1, B2, C0, C1, C2, Area2, tri_empty, commit
  );
endinterface

// File: rtl/tri_edge_setup.sv
// Triangle edge-function setup: computes A/B/C per edge into a shadow set over
// three cycles with one shared multiplier pair, orients the triangle so inside
// pixels evaluate >= 0, and commits the shadow to the active outputs on frame_start.
module tri_edge_setup (
  input  logic            VGA_CLK,
  input  logic            Rst_n,
  tri_edge_setup_if.slave bus
);

  localparam int unsigned VW  = 10;
  localparam int unsigned AW  = 11;
  localparam int unsigned CW  = 21;
  localparam int unsigned ARW = 23;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC0, S_CALC1, S_CALC2, S_ORIENT, S_PENDING
  } state_t;

  state_t state_q, state_d;

  logic                 ready_q;
  logic [VW-1:0]        vx_q [3];
  logic [VW-1:0]        vy_q [3];
  logic signed [AW-1:0] sh_a_q [3];
  logic signed [AW-1:0] sh_b_q [3];
  logic signed [CW-1:0] sh_c_q [3];
  logic signed [ARW-1:0] sh_area_q;
  logic                 sh_empty_q;
  logic signed [AW-1:0] act_a_q [3];
  logic signed [AW-1:0] act_b_q [3];
  logic signed [CW-1:0] act_c_q [3];
  logic signed [ARW-1:0] act_area_q;
  logic                 act_empty_q;
  logic                 commit_q;

  logic                 transfer_c;
  logic                 load_c, calc_c, orient_c, commit_c;
  logic [1:0]           idx_c, idx_b_c;
  logic [VW-1:0]        xa_c, ya_c, xb_c, yb_c;
  logic [2*VW-1:0]      prod_ab_c, prod_ba_c;
  logic signed [AW-1:0] edge_a_c, edge_b_c;
  logic signed [CW-1:0] edge_c_c;
  logic signed [ARW-1:0] raw_area_c;

  assign transfer_c = bus.vtx_valid & ready_q;

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    calc_c   = 1'b0;
    orient_c = 1'b0;
    commit_c = 1'b0;
    idx_c    = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (transfer_c) begin
          load_c  = 1'b1;
          state_d = S_CALC0;
        end
      end
      S_CALC0: begin
        calc_c  = 1'b1;
        idx_c   = 2'd0;
        state_d = S_CALC1;
      end
      S_CALC1: begin
        calc_c  = 1'b1;
        idx_c   = 2'd1;
        state_d = S_CALC2;
      end
      S_CALC2: begin
        calc_c  = 1'b1;
        idx_c   = 2'd2;
        state_d = S_ORIENT;
      end
      S_ORIENT: begin
        orient_c = 1'b1;
        state_d  = S_PENDING;
      end
      S_PENDING: begin
        if (bus.frame_start) begin
          commit_c = 1'b1;
          state_d  = S_IDLE;
        end
        if (transfer_c) begin
          load_c  = 1'b1;
          state_d = S_CALC0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shared edge datapath: edge k runs from vertex k to vertex (k+1) mod 3.
  always_comb begin
    idx_b_c    = (idx_c == 2'd2) ? 2'd0 : idx_c + 2'd1;
    xa_c       = vx_q[idx_c];
    ya_c       = vy_q[idx_c];
    xb_c       = vx_q[idx_b_c];
    yb_c       = vy_q[idx_b_c];
    prod_ab_c  = xa_c * yb_c;
    prod_ba_c  = xb_c * ya_c;
    edge_a_c   = $signed({1'b0, ya_c}) - $signed({1'b0, yb_c});
    edge_b_c   = $signed({1'b0, xb_c}) - $signed({1'b0, xa_c});
    edge_c_c   = $signed({1'b0, prod_ab_c}) - $signed({1'b0, prod_ba_c});
    raw_area_c = {{2{sh_c_q[0][CW-1]}}, sh_c_q[0]}
               + {{2{sh_c_q[1][CW-1]}}, sh_c_q[1]}
               + {{2{sh_c_q[2][CW-1]}}, sh_c_q[2]};
  end

  // State, handshake and commit pulse registers.
  always_ff @(posedge VGA_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == S_IDLE) || (state_d == S_PENDING);
      commit_q <= commit_c;
    end
  end

  // Vertex capture and shadow coefficient set.
  always_ff @(posedge VGA_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 3; i++) begin
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
        sh_a_q[i] <= '0;
        sh_b_q[i] <= '0;
        sh_c_q[i] <= '0;
      end
      sh_area_q  <= '0;
      sh_empty_q <= 1'b1;
    end else begin
      if (load_c) begin
        vx_q[0] <= bus.x1;
        vy_q[0] <= bus.y1;
        vx_q[1] <= bus.x2;
        vy_q[1] <= bus.y2;
        vx_q[2] <= bus.x3;
        vy_q[2] <= bus.y3;
      end
      if (calc_c) begin
        sh_a_q[idx_c] <= edge_a_c;
        sh_b_q[idx_c] <= edge_b_c;
        sh_c_q[idx_c] <= edge_c_c;
      end
      if (orient_c) begin
        // Clockwise winding flips every edge so the inside test stays ">= 0".
        if (raw_area_c < 0) begin
          for (int i = 0; i < 3; i++) begin
            sh_a_q[i] <= -sh_a_q[i];
            sh_b_q[i] <= -sh_b_q[i];
            sh_c_q[i] <= -sh_c_q[i];
          end
          sh_area_q <= -raw_area_c;
        end else begin
          sh_area_q <= raw_area_c;
        end
        sh_empty_q <= (raw_area_c == '0);
      end
    end
  end

  // Active set seen by the painter; only changes on a commit.
  always_ff @(posedge VGA_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 3; i++) begin
        act_a_q[i] <= '0;
        act_b_q[i] <= '0;
        act_c_q[i] <= '0;
      end
      act_area_q  <= '0;
      act_empty_q <= 1'b1;
    end else if (commit_c) begin
      for (int i = 0; i < 3; i++) begin
        act_a_q[i] <= sh_a_q[i];
        act_b_q[i] <= sh_b_q[i];
        act_c_q[i] <= sh_c_q[i];
      end
      act_area_q  <= sh_area_q;
      act_empty_q <= sh_empty_q;
    end
  end

  assign bus.vtx_ready = ready_q;
  assign bus.A0        = act_a_q[0];
  assign bus.A1        = act_a_q[1];
  assign bus.A2        = act_a_q[2];
  assign bus.B0        = act_b_q[0];
  assign bus.B1        = act_b_q[1];
  assign bus.B2        = act_b_q[2];
  assign bus.C0        = act_c_q[0];
  assign bus.C1        = act_c_q[1];
  assign bus.C2        = act_c_q[2];
  assign bus.Area2     = act_area_q;
  assign bus.tri_empty = act_empty_q;
  assign bus.commit    = commit_q;

endmodule

// File: tb/tb_tri_edge_setup.sv
// Bench for tri_edge_setup: directed scenarios plus random triangles checked
// against an arithmetic edge-function model.
module tb_tri_edge_setup;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  tri_edge_setup_if bus();

  tri_edge_setup dut (
    .VGA_CLK (clk),
    .Rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Expected active set, packed {A0,A1,A2,B0,B1,B2,C0,C1,C2,Area2,tri_empty}.
  logic [152:0] exp_act;
  localparam logic [152:0] RESET_VEC = 153'd1;

  function automatic logic [152:0] model(int x1, int y1, int x2, int y2, int x3, int y3);
    int xs[3];
    int ys[3];
    int a[3];
    int b[3];
    int c[3];
    int area;
    xs[0] = x1; xs[1] = x2; xs[2] = x3;
    ys[0] = y1; ys[1] = y2; ys[2] = y3;
    for (int i = 0; i < 3; i++) begin
      a[i] = ys[i] - ys[(i + 1) % 3];
      b[i] = xs[(i + 1) % 3] - xs[i];
      c[i] = xs[i] * ys[(i + 1) % 3] - xs[(i + 1) % 3] * ys[i];
    end
    area = c[0] + c[1] + c[2];
    if (area < 0) begin
      for (int i = 0; i < 3; i++) begin
        a[i] = -a[i];
        b[i] = -b[i];
        c[i] = -c[i];
      end
      area = -area;
    end
    return {11'(a[0]), 11'(a[1]), 11'(a[2]), 11'(b[0]), 11'(b[1]), 11'(b[2]),
            21'(c[0]), 21'(c[1]), 21'(c[2]), 23'(area), (area == 0)};
  endfunction

  function automatic logic [152:0] dut_vec();
    return {bus.A0, bus.A1, bus.A2, bus.B0, bus.B1, bus.B2,
            bus.C0, bus.C1, bus.C2, bus.Area2, bus.tri_empty};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vertex set once ready is seen; returns just after the transfer edge.
  task automatic load(int x1, int y1, int x2, int y2, int x3, int y3);
    int n;
    n = 0;
    while (bus.vtx_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n >= 20) $display("FAIL load_ready_timeout: vtx_ready=%b after %0d cycles, required 1", bus.vtx_ready, n);
    else passed++;
    bus.x1 = 10'(x1); bus.y1 = 10'(y1);
    bus.x2 = 10'(x2); bus.y2 = 10'(y2);
    bus.x3 = 10'(x3); bus.y3 = 10'(y3);
    bus.vtx_valid = 1'b1;
    step();
    bus.vtx_valid = 1'b0;
  endtask

  task automatic wait_pending(string name);
    int n;
    n = 0;
    while (bus.vtx_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n >= 20) $display("FAIL %s_pending_timeout: vtx_ready=%b, required 1", name, bus.vtx_ready);
    else passed++;
  endtask

  task automatic test_reset();
    bus.vtx_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;
    rst_n = 1'b0;
    exp_act = RESET_VEC;
    repeat (3) step();
    total++;
    if (dut_vec() !== RESET_VEC) $display("FAIL reset_outputs: got %h, required %h", dut_vec(), RESET_VEC);
    else passed++;
    total++;
    if (bus.commit !== 1'b0) $display("FAIL reset_commit: got %b, required 0", bus.commit);
    else passed++;
    rst_n = 1'b1;
    step();
    total++;
    if (bus.vtx_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.vtx_ready);
    else passed++;
  endtask

  task automatic test_known();
    int a0, a1, a2, b0, b1, b2, c0, c1, c2, ar, e0, e1, e2;
    logic [152:0] want;
    load(340, 50, 120, 450, 340, 450);
    wait_pending("known");
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    want = {11'sd400, 11'sd0, -11'sd400, 11'sd220, -11'sd220, 11'sd0,
            -21'sd147000, 21'sd99000, 21'sd136000, 23'sd88000, 1'b0};
    exp_act = want;
    total++;
    if (bus.commit !== 1'b1) $display("FAIL known_commit: got %b, required 1", bus.commit);
    else passed++;
    total++;
    if (dut_vec() !== want) $display("FAIL known_coeffs: got %h, required %h", dut_vec(), want);
    else passed++;
    a0 = bus.A0; a1 = bus.A1; a2 = bus.A2;
    b0 = bus.B0; b1 = bus.B1; b2 = bus.B2;
    c0 = bus.C0; c1 = bus.C1; c2 = bus.C2; ar = bus.Area2;
    e0 = a0 * 300 + b0 * 400 + c0;
    e1 = a1 * 300 + b1 * 400 + c1;
    e2 = a2 * 300 + b2 * 400 + c2;
    total++;
    if (e0 !== 61000 || e1 !== 11000 || e2 !== 16000 || e0 + e1 + e2 !== ar)
      $display("FAIL known_inside_point: edges %0d %0d %0d area %0d, required 61000 11000 16000 sum=area", e0, e1, e2, ar);
    else passed++;
    e0 = a0 * 100 + b0 * 100 + c0;
    e1 = a1 * 100 + b1 * 100 + c1;
    e2 = a2 * 100 + b2 * 100 + c2;
    total++;
    if (!(e0 < 0 || e1 < 0 || e2 < 0)) $display("FAIL known_outside_point: edges %0d %0d %0d, required one negative", e0, e1, e2);
    else passed++;
    step();
    total++;
    if (bus.commit !== 1'b0) $display("FAIL known_commit_width: got %b, required 0", bus.commit);
    else passed++;
  endtask

  task automatic test_idle_frame_ignored();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    total++;
    if (bus.commit !== 1'b0 || dut_vec() !== exp_act)
      $display("FAIL idle_frame: commit %b out %h, required 0 %h", bus.commit, dut_vec(), exp_act);
    else passed++;
  endtask

  task automatic test_degenerate();
    int commits;
    load(0, 0, 10, 10, 20, 20);
    wait_pending("degen");
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    commits = (bus.commit === 1'b1) ? 1 : 0;
    exp_act = model(0, 0, 10, 10, 20, 20);
    total++;
    if (bus.Area2 !== 23'sd0 || bus.tri_empty !== 1'b1 || dut_vec() !== exp_act)
      $display("FAIL degen_outputs: area %0d empty %b, required 0 1", bus.Area2, bus.tri_empty);
    else passed++;
    repeat (4) begin
      step();
      if (bus.commit === 1'b1) commits++;
    end
    total++;
    if (commits !== 1) $display("FAIL degen_commit_count: got %0d, required 1", commits);
    else passed++;
  endtask

  task automatic test_frame_during_calc();
    logic [152:0] p;
    p = model(100, 200, 500, 220, 300, 700);
    load(100, 200, 500, 220, 300, 700);
    step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    total++;
    if (bus.commit !== 1'b0 || dut_vec() !== exp_act)
      $display("FAIL calc_frame_ignored: commit %b out %h, required 0 %h", bus.commit, dut_vec(), exp_act);
    else passed++;
    wait_pending("calc_frame");
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    exp_act = p;
    total++;
    if (bus.commit !== 1'b1 || dut_vec() !== p)
      $display("FAIL calc_frame_later_commit: commit %b out %h, required 1 %h", bus.commit, dut_vec(), p);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [152:0] p, q;
    p = model(10, 10, 600, 30, 200, 400);
    q = model(900, 900, 50, 800, 700, 20);
    load(10, 10, 600, 30, 200, 400);
    wait_pending("b2b");
    bus.x1 = 10'd900; bus.y1 = 10'd900; bus.x2 = 10'd50;
    bus.y2 = 10'd800; bus.x3 = 10'd700; bus.y3 = 10'd20;
    bus.vtx_valid = 1'b1;
    bus.frame_start = 1'b1;
    step();
    bus.vtx_valid = 1'b0;
    bus.frame_start = 1'b0;
    exp_act = p;
    total++;
    if (bus.commit !== 1'b1 || dut_vec() !== p || bus.vtx_ready !== 1'b0)
      $display("FAIL b2b_commit_p: commit %b ready %b out %h, required 1 0 %h", bus.commit, bus.vtx_ready, dut_vec(), p);
    else passed++;
    wait_pending("b2b_q");
    total++;
    if (dut_vec() !== p) $display("FAIL b2b_hold_p: got %h, required %h", dut_vec(), p);
    else passed++;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    exp_act = q;
    total++;
    if (bus.commit !== 1'b1 || dut_vec() !== q)
      $display("FAIL b2b_commit_q: commit %b out %h, required 1 %h", bus.commit, dut_vec(), q);
    else passed++;
  endtask

  task automatic test_pending_replace();
    logic [152:0] q;
    q = model(512, 0, 0, 1023, 1023, 1023);
    load(3, 4, 400, 5, 7, 300);
    wait_pending("replace");
    load(512, 0, 0, 1023, 1023, 1023);
    total++;
    if (bus.commit !== 1'b0 || dut_vec() !== exp_act)
      $display("FAIL replace_no_commit: commit %b out %h, required 0 %h", bus.commit, dut_vec(), exp_act);
    else passed++;
    wait_pending("replace_q");
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    exp_act = q;
    total++;
    if (bus.commit !== 1'b1 || dut_vec() !== q)
      $display("FAIL replace_commit_q: commit %b out %h, required 1 %h", bus.commit, dut_vec(), q);
    else passed++;
  endtask

  task automatic test_reset_mid_calc();
    int commits;
    load(1, 2, 800, 3, 400, 900);
    step();
    step();
    #5 rst_n = 1'b0;
    #1;
    exp_act = RESET_VEC;
    total++;
    if (dut_vec() !== RESET_VEC || bus.commit !== 1'b0)
      $display("FAIL midreset_async: out %h commit %b, required %h 0", dut_vec(), bus.commit, RESET_VEC);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (bus.vtx_ready !== 1'b1) $display("FAIL midreset_ready: got %b, required 1", bus.vtx_ready);
    else passed++;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    commits = (bus.commit === 1'b1) ? 1 : 0;
    repeat (6) begin
      step();
      if (bus.commit === 1'b1) commits++;
    end
    total++;
    if (commits !== 0 || dut_vec() !== RESET_VEC)
      $display("FAIL midreset_no_commit: commits %0d out %h, required 0 %h", commits, dut_vec(), RESET_VEC);
    else passed++;
  endtask

  task automatic test_random();
    int v[6];
    int n;
    int lat_bad;
    int out_bad;
    lat_bad = 0;
    out_bad = 0;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 6; k++) v[k] = int'($urandom_range(0, 1023));
      if (t % 8 == 7) begin
        v[4] = v[0];
        v[5] = v[1];
      end
      load(v[0], v[1], v[2], v[3], v[4], v[5]);
      n = 0;
      while (bus.vtx_ready !== 1'b1 && n < 20) begin
        // Junk offered while not ready must not be captured.
        bus.vtx_valid = (n < 3);
        bus.x1 = 10'($urandom); bus.y1 = 10'($urandom);
        bus.x2 = 10'($urandom); bus.y2 = 10'($urandom);
        step();
        n++;
      end
      bus.vtx_valid = 1'b0;
      if (n !== 4) begin
        lat_bad++;
        $display("FAIL rand_latency: trial %0d took %0d edges, required 4", t, n);
      end
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      exp_act = model(v[0], v[1], v[2], v[3], v[4], v[5]);
      if (bus.commit !== 1'b1 || dut_vec() !== exp_act) begin
        out_bad++;
        $display("FAIL rand_coeffs: trial %0d commit %b out %h, required 1 %h", t, bus.commit, dut_vec(), exp_act);
      end
      step();
    end
    total++;
    if (lat_bad !== 0) $display("FAIL rand_latency_total: %0d bad trials, required 0", lat_bad);
    else passed++;
    total++;
    if (out_bad !== 0) $display("FAIL rand_coeffs_total: %0d bad trials, required 0", out_bad);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_known();
    test_idle_frame_ignored();
    test_degenerate();
    test_frame_during_calc();
    test_back_to_back();
    test_pending_replace();
    test_reset_mid_calc();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
